pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 20 ++
 rtl/adder_stage.sv | 36 +++
 rtl/pipelined_adder.sv | 102 ++++++++++
 tb/tb_pipelined_adder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the chunked pipelined adder: operation encoding and
// the record that travels down the pipeline alongside each transaction.
package pipelined_adder_pkg;

  // Upper bound on WIDTH; payload vectors are sized to it and zero-extended.
  localparam int MAX_WIDTH = 64;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic                 mode;
    logic                 carry;
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
  } stage_payload_t;

endpackage

// File: rtl/adder_stage.sv
// One pipeline stage: adds chunk INDEX of the pending operands plus the incoming
// carry, writes that chunk of the partial sum, and registers the whole record.
module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = 4,
  parameter int INDEX = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           advance,
  input  stage_payload_t din,
  output stage_payload_t dout
);

  logic [CHUNK:0] chunk_sum;
  stage_payload_t staged;

  always_comb begin
    chunk_sum = {1'b0, din.a[INDEX*CHUNK +: CHUNK]}
              + {1'b0, din.b[INDEX*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, din.carry};
    staged = din;
    staged.sum[INDEX*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    staged.carry = chunk_sum[CHUNK];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout <= '0;
    end else if (advance) begin
      dout <= staged;
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder/accumulator: WIDTH-bit add split into STAGES carry-chained
// chunks, with valid/ready handshakes and a single-in-flight accumulate mode.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] acc
);

  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH < 2 || WIDTH > MAX_WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be 2..MAX_WIDTH and a multiple of STAGES");
  end

  stage_payload_t   entry;
  stage_payload_t   stage_in  [STAGES];
  stage_payload_t   stage_out [STAGES];
  stage_payload_t   result;
  logic             advance;
  logic             acc_busy;
  logic [WIDTH-1:0] acc_q;

  assign result    = stage_out[STAGES-1];
  assign out_valid = result.valid;
  assign sum       = result.sum[WIDTH-1:0];
  assign carry     = result.carry;
  assign acc       = acc_q;
  assign advance   = en && (!out_valid || out_ready);
  assign in_ready  = reset_n && advance && !acc_busy;

  // An accumulate must see the previous accumulate's result, so only one may be in flight.
  always_comb begin
    acc_busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (stage_out[k].valid && (stage_out[k].mode == MODE_ACC)) begin
        acc_busy = 1'b1;
      end
    end
  end

  always_comb begin
    entry       = '0;
    entry.valid = in_valid && in_ready;
    entry.mode  = mode;
    entry.carry = cin;
    entry.a     = MAX_WIDTH'(a);
    entry.b     = (mode == MODE_ACC) ? MAX_WIDTH'(acc_q) : MAX_WIDTH'(b);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign stage_in[k] = entry;
    end else begin : g_chain
      assign stage_in[k] = stage_out[k-1];
    end

    adder_stage #(
      .CHUNK (CHUNK),
      .INDEX (k)
    ) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .advance (advance),
      .din     (stage_in[k]),
      .dout    (stage_out[k])
    );
  end

  // Clear takes priority over loading a completing accumulate result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else if (en) begin
      if (acc_clr) begin
        acc_q <= '0;
      end else if (out_valid && out_ready && (result.mode == MODE_ACC)) begin
        acc_q <= sum;
      end
    end
  end

  logic unused_payload;
  assign unused_payload = ^{result.a, result.b, result.sum};

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=8, STAGES=2) with a
// scoreboard queue filled on acceptance and drained on output consumption.
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       mode;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;
  logic [7:0] acc;

  typedef struct {
    logic [8:0] res;
    logic       m;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         received = 0;
  int         base;
  int         waitCount;
  logic [7:0] modelAcc = '0;
  logic       lastAccepted = 1'b0;
  logic [7:0] b2bOps [4] = '{8'h01, 8'h02, 8'h03, 8'h80};

  pipelined_adder #(
    .WIDTH  (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .mode      (mode),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic m, input logic [7:0] av,
                               input logic [7:0] bv, input logic c);
    in_valid = v;
    mode     = m;
    a        = av;
    b        = bv;
    cin      = c;
  endtask

  task automatic idle();
    applyStimulus(1'b0, MODE_ADD, 8'h00, 8'h00, 1'b0);
  endtask

  // One clock: scoreboard bookkeeping from pre-edge handshakes, then the edge.
  task automatic tick();
    logic       accepted;
    logic       consumed;
    logic [8:0] pushRes;
    exp_t       e;
    #1;
    accepted = reset_n && in_valid && in_ready;
    consumed = reset_n && en && out_valid && out_ready;
    if (mode == MODE_ACC)
      pushRes = {1'b0, modelAcc} + {1'b0, a} + {8'd0, cin};
    else
      pushRes = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    if (!reset_n) begin
      sb.delete();
      modelAcc = '0;
    end else begin
      if (consumed) begin
        received++;
        if (sb.size() == 0) begin
          checkOutput("spurious_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", {23'd0, carry, sum}, {23'd0, e.res});
          if (e.m) modelAcc = e.res[7:0];
        end
      end
      if (en && acc_clr) modelAcc = '0;
      if (accepted) begin
        e.res = pushRes;
        e.m   = mode;
        sb.push_back(e);
      end
    end
    lastAccepted = accepted;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    acc_clr   = 1'b0;
    idle();
    tick();
    tick();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_carry", 32'(carry), 32'd0);
    checkOutput("rst_acc", 32'(acc), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);

    // 0xFF + 0x01 wraps with carry after exactly two cycles.
    applyStimulus(1'b1, MODE_ADD, 8'hFF, 8'h01, 1'b0);
    tick();
    checkOutput("lat_accept", 32'(lastAccepted), 32'd1);
    checkOutput("lat_early", 32'(out_valid), 32'd0);
    idle();
    tick();
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("ff_sum", 32'(sum), 32'h00);
    checkOutput("ff_carry", 32'(carry), 32'd1);
    drain("ff");

    // Back-to-back adds stream out on consecutive cycles.
    base = received;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, MODE_ADD, b2bOps[i], b2bOps[i], 1'b0);
      tick();
      checkOutput("b2b_accept", 32'(lastAccepted), 32'd1);
    end
    idle();
    tick();
    checkOutput("b2b_last_sum", 32'(sum), 32'h00);
    checkOutput("b2b_last_carry", 32'(carry), 32'd1);
    tick();
    checkOutput("b2b_count", 32'(received - base), 32'd4);

    // Output stall with a full pipeline.
    base = received;
    out_ready = 1'b0;
    applyStimulus(1'b1, MODE_ADD, 8'h10, 8'h05, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ADD, 8'h20, 8'h07, 1'b1);
    tick();
    applyStimulus(1'b1, MODE_ADD, 8'h30, 8'h09, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_sum_held", 32'(sum), 32'h15);
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("stall_release_accept", 32'(lastAccepted), 32'd1);
    idle();
    drain("stall");
    checkOutput("stall_count", 32'(received - base), 32'd3);

    // Accumulate: second operand waits until the first result is consumed.
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    checkOutput("clr_acc", 32'(acc), 32'd0);
    applyStimulus(1'b1, MODE_ACC, 8'hF0, 8'h55, 1'b0);
    tick();
    checkOutput("acc1_accept", 32'(lastAccepted), 32'd1);
    applyStimulus(1'b1, MODE_ACC, 8'h20, 8'hAA, 1'b0);
    #1;
    checkOutput("acc_busy_ready", 32'(in_ready), 32'd0);
    lastAccepted = 1'b0;
    waitCount = 0;
    while (!lastAccepted && waitCount < 10) begin
      tick();
      waitCount++;
    end
    checkOutput("acc2_wait", 32'(waitCount), 32'd3);
    checkOutput("acc_first", 32'(acc), 32'hF0);
    idle();
    drain("acc");
    checkOutput("acc_second", 32'(acc), 32'h10);

    // Clear on the cycle an accumulate completes wins.
    applyStimulus(1'b1, MODE_ACC, 8'h05, 8'h00, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("accclr_pending_sum", 32'(sum), 32'h15);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    checkOutput("accclr_wins", 32'(acc), 32'd0);
    checkOutput("accclr_out_valid", 32'(out_valid), 32'd0);

    // Reset with two transactions in flight, one of them an accumulate.
    applyStimulus(1'b1, MODE_ADD, 8'h44, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b1, MODE_ACC, 8'h07, 8'h00, 1'b1);
    tick();
    checkOutput("rst_mid_accept", 32'(lastAccepted), 32'd1);
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rst_mid_no_out", 32'(out_valid), 32'd0);
    end
    checkOutput("rst_mid_acc", 32'(acc), 32'd0);

    // En low freezes everything, including a pending clear.
    applyStimulus(1'b1, MODE_ACC, 8'h3C, 8'h00, 1'b0);
    tick();
    idle();
    drain("prefreeze");
    checkOutput("prefreeze_acc", 32'(acc), 32'h3C);
    applyStimulus(1'b1, MODE_ADD, 8'h33, 8'h11, 1'b0);
    tick();
    idle();
    out_ready = 1'b0;
    tick();
    en = 1'b0;
    out_ready = 1'b1;
    acc_clr = 1'b1;
    applyStimulus(1'b1, MODE_ADD, 8'h01, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("freeze_in_ready", 32'(in_ready), 32'd0);
      checkOutput("freeze_out_valid", 32'(out_valid), 32'd1);
      checkOutput("freeze_sum", 32'(sum), 32'h44);
      checkOutput("freeze_carry", 32'(carry), 32'd0);
      checkOutput("freeze_acc", 32'(acc), 32'h3C);
    end
    en = 1'b1;
    acc_clr = 1'b0;
    idle();
    drain("freeze");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
